// File: rtl/sseg_value_ctrl_pkg.sv
// Shared FSM encodings, digit attribute type and clamp-limit helpers for the
// sseg_value_ctrl write sequencer.
package sseg_value_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ABS   = 3'd1;
  localparam logic [2:0] ST_CONV  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic [3:0] val;
    logic       en;
    logic       sign;
    logic       dp;
  } digit_attr_t;

  function automatic int bcd_width(input int n);
    return 4 * n;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [63:0] pos_limit(input int n);
    return pow10(n) - 64'd1;
  endfunction

  // One digit is given up to the minus glyph.
  function automatic logic [63:0] neg_limit(input int n);
    return pow10(n - 1) - 64'd1;
  endfunction

endpackage

// File: rtl/sseg_value_ctrl_bin2bcd.sv
// Sequential double-dabble: one shift/add-3 step per cycle, done pulses
// VAL_BITS cycles after start with bcd held until the next start.
module bin2bcd #(
  parameter int VAL_BITS = 16,
  parameter int BCD_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [VAL_BITS-1:0] bin,
  output logic [BCD_W-1:0]    bcd,
  output logic                done
);
  localparam int CNT_W = $clog2(VAL_BITS + 1);

  // BCD accumulator on top, remaining binary bits below; the pair shifts as one.
  logic [BCD_W+VAL_BITS-1:0] dd_reg;
  logic [BCD_W-1:0]          adj;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      run_reg;
  logic                      done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      logic [3:0] d;
      assign d = dd_reg[VAL_BITS + 4*gi +: 4];
      assign adj[4*gi +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      dd_reg   <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        // First step needs no add-3: the accumulator starts at zero.
        dd_reg   <= {{BCD_W{1'b0}}, bin} << 1;
        cnt_reg  <= CNT_W'(1);
        run_reg  <= (VAL_BITS > 1);
        done_reg <= (VAL_BITS == 1);
      end else if (run_reg) begin
        dd_reg  <= {adj, dd_reg[VAL_BITS-1:0]} << 1;
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(VAL_BITS - 1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign bcd  = dd_reg[BCD_W+VAL_BITS-1:VAL_BITS];
  assign done = done_reg;

endmodule

// File: rtl/sseg_value_ctrl.sv
// Converts a signed value to BCD and writes every digit of sseg_array in turn,
// with blanking, minus glyph, decimal point and clamping; paced by done_tick.
module sseg_value_ctrl
  import sseg_value_ctrl_pkg::*;
#(
  parameter int SSEG_BITS = 3,
  parameter int SSEG_N    = 4,
  parameter int VAL_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VAL_BITS-1:0]  value,
  input  logic                 dp_en,
  input  logic [SSEG_BITS-1:0] dp_pos,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 wr,
  output logic [SSEG_BITS-1:0] sel,
  output logic [3:0]           val,
  output logic                 en,
  output logic                 sign,
  output logic                 dp,
  input  logic                 done_tick
);
  localparam int BCD_W = bcd_width(SSEG_N);
  localparam int SLOTS = 2**SSEG_BITS;
  localparam logic [63:0] POS_LIM = pos_limit(SSEG_N);
  localparam logic [63:0] NEG_LIM = neg_limit(SSEG_N);
  localparam logic [VAL_BITS-1:0] POS_LIM_V = POS_LIM[VAL_BITS-1:0];
  localparam logic [VAL_BITS-1:0] NEG_LIM_V = NEG_LIM[VAL_BITS-1:0];

  logic [2:0]           state_reg;
  logic [VAL_BITS-1:0]  value_reg, mag_reg, mag_raw;
  logic                 neg_reg, dp_en_reg, ovf_reg, bcd_start_reg, tick_reg;
  logic [SSEG_BITS-1:0] dp_pos_reg, k_reg;
  logic                 mag_over;
  logic [BCD_W-1:0]     bcd;
  logic                 bcd_done;

  // Two's-complement negate in VAL_BITS bits: the most negative value maps to 2^(VAL_BITS-1).
  assign mag_raw  = neg_reg ? (~value_reg + 1'b1) : value_reg;
  assign mag_over = neg_reg ? (64'(mag_raw) > NEG_LIM) : (64'(mag_raw) > POS_LIM);

  bin2bcd #(.VAL_BITS(VAL_BITS), .BCD_W(BCD_W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start_reg),
    .bin   (mag_reg),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      value_reg     <= '0;
      mag_reg       <= '0;
      neg_reg       <= 1'b0;
      dp_en_reg     <= 1'b0;
      dp_pos_reg    <= '0;
      ovf_reg       <= 1'b0;
      bcd_start_reg <= 1'b0;
      tick_reg      <= 1'b0;
      k_reg         <= '0;
    end else begin
      bcd_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: if (start) begin
          value_reg  <= value;
          neg_reg    <= value[VAL_BITS-1];
          dp_en_reg  <= dp_en;
          dp_pos_reg <= dp_pos;
          state_reg  <= ST_ABS;
        end
        ST_ABS: begin
          mag_reg       <= mag_over ? (neg_reg ? NEG_LIM_V : POS_LIM_V) : mag_raw;
          ovf_reg       <= mag_over;
          bcd_start_reg <= 1'b1;
          k_reg         <= '0;
          state_reg     <= ST_CONV;
        end
        ST_CONV: if (bcd_done) state_reg <= ST_WRITE;
        ST_WRITE: begin
          tick_reg  <= 1'b0;
          state_reg <= ST_WAIT;
        end
        // The first tick may land mid-refresh; only the second proves a full scan.
        ST_WAIT: if (done_tick) begin
          if (tick_reg) begin
            if (int'(k_reg) < SSEG_N - 1) begin
              k_reg     <= k_reg + 1'b1;
              state_reg <= ST_WRITE;
            end else begin
              state_reg <= ST_DONE;
            end
          end else begin
            tick_reg <= 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  logic [3:0]       digit_arr [SLOTS];
  logic [SLOTS-1:0] en_base;
  int               msd_i, top_i, dp_pos_i;
  logic             sign_here;
  digit_attr_t      attr;
  logic             active;

  assign dp_pos_i = int'(dp_pos_reg);

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_digit
      if (gi < SSEG_N) begin : g_real
        assign digit_arr[gi] = bcd[4*gi +: 4];
        assign en_base[gi]   = (gi <= msd_i) || (gi == 0) || (dp_en_reg && (gi <= dp_pos_i));
      end else begin : g_pad
        assign digit_arr[gi] = 4'd0;
        assign en_base[gi]   = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    msd_i = 0;
    for (int i = 0; i < SSEG_N; i++) if (digit_arr[i] != 4'd0) msd_i = i;
  end

  // Minus glyph goes one place above the highest lit digit, if that place exists.
  always_comb begin
    top_i = 0;
    for (int i = 0; i < SSEG_N; i++) if (en_base[i]) top_i = i;
    sign_here = neg_reg && (int'(k_reg) == top_i + 1);
    attr.val  = sign_here ? 4'd0 : digit_arr[k_reg];
    attr.en   = en_base[k_reg] || sign_here;
    attr.sign = sign_here;
    attr.dp   = dp_en_reg && (k_reg == dp_pos_reg);
  end

  assign active   = (state_reg == ST_WRITE) || (state_reg == ST_WAIT);
  assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done     = (state_reg == ST_DONE);
  assign overflow = done && ovf_reg;
  assign wr       = (state_reg == ST_WRITE);
  assign sel      = active ? k_reg : '0;
  assign val      = active ? attr.val : 4'd0;
  assign en       = active && attr.en;
  assign sign     = active && attr.sign;
  assign dp       = active && attr.dp;

endmodule

// File: tb/tb_sseg_value_ctrl.sv
// Directed bench for sseg_value_ctrl: arithmetic digit model checked on every
// write and hold cycle, plus literal digit tables for the listed cases.
module tb_sseg_value_ctrl;
  localparam int SSEG_BITS = 3;
  localparam int SSEG_N    = 4;
  localparam int VAL_BITS  = 16;
  localparam int LAT       = 3 + VAL_BITS;

  logic clk = 1'b0;
  logic reset, start, dp_en;
  logic done_tick = 1'b0;
  logic [VAL_BITS-1:0]  value;
  logic [SSEG_BITS-1:0] dp_pos;
  logic busy, done, overflow, wr, en, sign, dp;
  logic [SSEG_BITS-1:0] sel;
  logic [3:0] val;

  sseg_value_ctrl #(.SSEG_BITS(SSEG_BITS), .SSEG_N(SSEG_N), .VAL_BITS(VAL_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .dp_en(dp_en), .dp_pos(dp_pos),
    .busy(busy), .done(done), .overflow(overflow), .wr(wr), .sel(sel), .val(val),
    .en(en), .sign(sign), .dp(dp), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sseg_array refresh tick, one cycle in four.
  always @(negedge clk) done_tick = (cyc % 4 == 3);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: plain integer arithmetic on the requested value.
  int exp_val [SSEG_N];
  int exp_en  [SSEG_N];
  int exp_sign[SSEG_N];
  int exp_dp  [SSEG_N];
  int exp_ovf;

  task automatic build_model(input int v, input bit de, input int dpp);
    int mag, lim, msd, top, pw;
    bit neg;
    neg = (v < 0);
    mag = neg ? -v : v;
    lim = neg ? (10 ** (SSEG_N - 1)) - 1 : (10 ** SSEG_N) - 1;
    exp_ovf = (mag > lim) ? 1 : 0;
    if (mag > lim) mag = lim;
    msd = 0; pw = 1;
    for (int k = 0; k < SSEG_N; k++) begin
      exp_val[k] = (mag / pw) % 10;
      if (exp_val[k] != 0) msd = k;
      pw = pw * 10;
    end
    top = 0;
    for (int k = 0; k < SSEG_N; k++) begin
      exp_en[k]   = (k <= msd || k == 0 || (de && k <= dpp)) ? 1 : 0;
      exp_sign[k] = 0;
      exp_dp[k]   = (de && k == dpp) ? 1 : 0;
      if (exp_en[k] != 0) top = k;
    end
    if (neg && top + 1 < SSEG_N) begin
      exp_en[top+1] = 1; exp_sign[top+1] = 1; exp_val[top+1] = 0;
    end
  endtask

  bit mon_on = 1'b0;
  int nwr, ndone, start_cyc, cap_ovf;
  int cap_val[SSEG_N], cap_en[SSEG_N], cap_sign[SSEG_N], cap_dp[SSEG_N];
  logic [9:0] held;

  always @(negedge clk) begin
    if (mon_on) begin
      if (wr) begin
        if (nwr == 0) check("first_wr_latency", cyc - start_cyc, LAT);
        if (nwr < SSEG_N) begin
          $display("wr %0d: sel=%0d val=%0d en=%0d sign=%0d dp=%0d", nwr, sel, val, en, sign, dp);
          check("wr_sel", sel, nwr);
          check("wr_en", en, exp_en[nwr]);
          check("wr_sign", sign, exp_sign[nwr]);
          check("wr_dp", dp, exp_dp[nwr]);
          if (exp_en[nwr] != 0) check("wr_val", val, exp_val[nwr]);
          cap_val[nwr] = val; cap_en[nwr] = en; cap_sign[nwr] = sign; cap_dp[nwr] = dp;
        end else begin
          check("wr_count_exceeded", nwr + 1, SSEG_N);
        end
        held = {sel, val, en, sign, dp};
        nwr++;
      end else if (busy && nwr > 0) begin
        check("hold_stable", {sel, val, en, sign, dp}, held);
      end
      if (done) begin
        ndone++;
        cap_ovf = overflow;
        check("done_overflow", overflow, exp_ovf);
        check("done_after_all_writes", nwr, SSEG_N);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  task automatic run_case(input string nm, input int v, input bit de, input int dpp, input int extra_at);
    bit got;
    build_model(v, de, dpp);
    @(negedge clk);
    nwr = 0; ndone = 0;
    value = VAL_BITS'(v); dp_en = de; dp_pos = SSEG_BITS'(dpp);
    start = 1'b1; start_cyc = cyc; mon_on = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_next_cycle"}, busy, 1);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = (i == extra_at);
      #1;
      if (ndone > 0) begin got = 1'b1; break; end
    end
    start = 1'b0;
    if (!got) check({nm, "_done_timeout"}, 0, 1);
    repeat (30) @(negedge clk);
    check({nm, "_done_count"}, ndone, 1);
    check({nm, "_write_count"}, nwr, SSEG_N);
    $display("case %s value=%0d dp_en=%0d dp_pos=%0d ovf=%0d", nm, v, de, dpp, cap_ovf);
  endtask

  task automatic check_caps(input string nm, input logic [3:0] em, input logic [3:0] sm,
                            input logic [3:0] dm, input logic [15:0] vals, input int ovf);
    for (int k = 0; k < SSEG_N; k++) begin
      check({nm, "_lit_en"}, cap_en[k], em[k]);
      check({nm, "_lit_sign"}, cap_sign[k], sm[k]);
      check({nm, "_lit_dp"}, cap_dp[k], dm[k]);
      if (em[k]) check({nm, "_lit_val"}, cap_val[k], vals[4*k +: 4]);
    end
    check({nm, "_lit_ovf"}, cap_ovf, ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int wr_seen;
    bit got;
    reset = 1'b1; start = 1'b0; value = '0; dp_en = 1'b0; dp_pos = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, overflow, wr, sel, val, en, sign, dp}, 0);
    reset = 1'b0;

    run_case("plain_1234", 1234, 1'b0, 0, -1);
    check_caps("plain_1234", 4'b1111, 4'b0000, 4'b0000, 16'h1234, 0);
    run_case("blank_7", 7, 1'b0, 0, -1);
    check_caps("blank_7", 4'b0001, 4'b0000, 4'b0000, 16'h0007, 0);
    run_case("zero", 0, 1'b0, 0, -1);
    check_caps("zero", 4'b0001, 4'b0000, 4'b0000, 16'h0000, 0);
    run_case("neg_42", -42, 1'b0, 0, -1);
    check_caps("neg_42", 4'b0111, 4'b0100, 4'b0000, 16'h0042, 0);
    run_case("clamp_12000", 12000, 1'b0, 0, -1);
    check_caps("clamp_12000", 4'b1111, 4'b0000, 4'b0000, 16'h9999, 1);
    run_case("clamp_m5000", -5000, 1'b0, 0, -1);
    check_caps("clamp_m5000", 4'b1111, 4'b1000, 4'b0000, 16'h0999, 1);
    run_case("clamp_m32768", -32768, 1'b0, 0, -1);
    check_caps("clamp_m32768", 4'b1111, 4'b1000, 4'b0000, 16'h0999, 1);
    run_case("dp_5", 5, 1'b1, 2, -1);
    check_caps("dp_5", 4'b0111, 4'b0000, 4'b0100, 16'h0005, 0);
    run_case("neg_dp_m3", -3, 1'b1, 1, -1);
    run_case("start_while_busy", 1234, 1'b0, 0, 30);

    // Reset pulsed while waiting after the sel1 write.
    build_model(9876, 1'b0, 0);
    @(negedge clk);
    nwr = 0; ndone = 0; value = VAL_BITS'(9876); start = 1'b1; start_cyc = cyc; mon_on = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (nwr >= 2) begin got = 1'b1; break; end
    end
    if (!got) check("reset_test_wr_timeout", 0, 1);
    @(negedge clk);
    check("reset_test_in_wait", busy && !wr, 1);
    mon_on = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_midrun_outputs", {busy, done, overflow, wr, sel, val, en, sign, dp}, 0);
    reset = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wr || done || busy) wr_seen++;
    end
    check("reset_no_further_activity", wr_seen, 0);
    $display("case reset_mid_wait activity_after_reset=%0d", wr_seen);

    run_case("after_reset_1234", 1234, 1'b0, 0, -1);
    check_caps("after_reset_1234", 4'b1111, 4'b0000, 4'b0000, 16'h1234, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
